// File: rtl/event_generation.sv
// Clock-event transmitter: drives a programmable clock on the pos/neg pin pair.
// Latency: enable sampled at edge N gives primary high with a rise strobe at N+1; pins are registered.
// Backpressure: none. The output runs freely; stopping waits for the next period boundary.
//
// Ports:
//   sys_dom_i       : clock (.clk) and async active-low reset (.rst_n)
//   generation_en_i : level request to run; dropping it stops at the next would-be rise
//   source_select_i : 1 = pos is primary, 0 = neg is primary (latched at start)
//   mode_i          : 0 single-ended, 1 differential, 2 quad-state, 3 as single-ended (latched at start)
//   half_period_i   : half period in clk cycles (0 acts as 1, quad-state minimum 2)
//   io_clk_o        : registered pos/neg pins
//   primary_rise_o  : one-cycle strobe coincident with the primary rising
//   primary_fall_o  : one-cycle strobe coincident with the primary falling
//   busy_o          : FSM is not idle

package common_p;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;
endpackage

package clks_alot_p;
  typedef struct packed {
    logic pos;
    logic neg;
  } recovery_pins_s;
endpackage

module event_generation #(
  parameter int COUNTER_WIDTH = 16
) (
  input  common_p::clk_dom_s          sys_dom_i,
  input  logic                        generation_en_i,
  input  logic                        source_select_i,
  input  logic [1:0]                  mode_i,
  input  logic [COUNTER_WIDTH-1:0]    half_period_i,
  output clks_alot_p::recovery_pins_s io_clk_o,
  output logic                        primary_rise_o,
  output logic                        primary_fall_o,
  output logic                        busy_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] STOPPING  = 2'd2;

  localparam logic [1:0] MODE_DIFF = 2'd1;
  localparam logic [1:0] MODE_QUAD = 2'd2;

  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] TWO = COUNTER_WIDTH'(2);

  logic clk;
  logic rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  // Effective half period: 0 acts as 1, and quad-state needs at least 2 so Q >= 1.
  function automatic logic [COUNTER_WIDTH-1:0] eff_half(input logic [COUNTER_WIDTH-1:0] hp,
                                                       input logic quad);
    logic [COUNTER_WIDTH-1:0] h;
    h = (hp == '0) ? ONE : hp;
    if (quad && (h < TWO)) h = TWO;
    return h;
  endfunction

  logic [1:0]               state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic                     src_q, src_d;
  logic [COUNTER_WIDTH-1:0] half_q, half_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] qcnt_q, qcnt_d;
  logic                     prim_q, prim_d;
  logic                     sec_q, sec_d;
  logic                     pos_q, pos_d;
  logic                     neg_q, neg_d;
  logic                     rise_q, rise_d;
  logic                     fall_q, fall_d;
  logic                     toggled;
  logic [COUNTER_WIDTH-1:0] h_start;
  logic [COUNTER_WIDTH-1:0] h_next;

  always_comb begin
    // Start uses the live mode; a period-boundary re-sample uses the latched one.
    h_start = eff_half(half_period_i, mode_i == MODE_QUAD);
    h_next  = eff_half(half_period_i, mode_q == MODE_QUAD);
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    qcnt_d  = qcnt_q;
    prim_d  = prim_q;
    sec_d   = sec_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    toggled = 1'b0;

    case (state_q)
      IDLE: begin
        // While idle the configuration tracks the live inputs, so it is latched on the start cycle.
        mode_d = mode_i;
        src_d  = source_select_i;
        cnt_d  = '0;
        qcnt_d = '0;
        prim_d = 1'b0;
        sec_d  = (mode_i == MODE_DIFF);
        if (generation_en_i) begin
          state_d = RUN;
          half_d  = h_start;
          cnt_d   = h_start - ONE;
          qcnt_d  = (mode_i == MODE_QUAD) ? (h_start >> 1) - ONE : '0;
          prim_d  = 1'b1;
          sec_d   = 1'b0;
          rise_d  = 1'b1;
        end
      end
      default: begin
        state_d = generation_en_i ? RUN : STOPPING;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (prim_q) begin
          prim_d  = 1'b0;
          fall_d  = 1'b1;
          toggled = 1'b1;
          cnt_d   = half_q - ONE;
          qcnt_d  = (half_q >> 1) - ONE;
        end else if (generation_en_i) begin
          // Period boundary: the only point where a new half period is picked up.
          prim_d  = 1'b1;
          rise_d  = 1'b1;
          toggled = 1'b1;
          half_d  = h_next;
          cnt_d   = h_next - ONE;
          qcnt_d  = (h_next >> 1) - ONE;
        end else begin
          // Would-be rise with no request: stay low, no strobe, and go idle.
          state_d = IDLE;
        end

        if (mode_q == MODE_QUAD) begin
          // Secondary holds across a primary toggle, then copies primary once the offset expires.
          if (!toggled) begin
            if (qcnt_q != '0) qcnt_d = qcnt_q - ONE;
            else              sec_d  = prim_q;
          end
        end else begin
          qcnt_d = '0;
          sec_d  = (mode_q == MODE_DIFF) ? ~prim_d : 1'b0;
        end
      end
    endcase

    pos_d = src_d ? prim_d : sec_d;
    neg_d = src_d ? sec_d  : prim_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      src_q   <= 1'b0;
      half_q  <= '0;
      cnt_q   <= '0;
      qcnt_q  <= '0;
      prim_q  <= 1'b0;
      sec_q   <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      qcnt_q  <= qcnt_d;
      prim_q  <= prim_d;
      sec_q   <= sec_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign io_clk_o.pos   = pos_q;
  assign io_clk_o.neg   = neg_q;
  assign primary_rise_o = rise_q;
  assign primary_fall_o = fall_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_event_generation.sv
// Bench for event_generation: directed scenarios plus random enable/config traffic
// compared every cycle against a period-phase reference model.
// Outputs are sampled on the falling clock edge.

module tb_event_generation;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  common_p::clk_dom_s sys_dom;
  assign sys_dom = {clk, rst_n};

  logic                        en;
  logic                        src;
  logic [1:0]                  mode;
  logic [CW-1:0]               hp;
  clks_alot_p::recovery_pins_s pins;
  logic                        rise;
  logic                        fall;
  logic                        busy;

  event_generation #(.COUNTER_WIDTH(CW)) dut (
    .sys_dom_i       (sys_dom),
    .generation_en_i (en),
    .source_select_i (src),
    .mode_i          (mode),
    .half_period_i   (hp),
    .io_clk_o        (pins),
    .primary_rise_o  (rise),
    .primary_fall_o  (fall),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: tracks where we are inside the current period (ph = cycles since the rise).
  bit       m_run;
  int       m_ph, m_h, m_q;
  bit [1:0] m_mode;
  bit       m_src;
  bit       e_pos, e_neg, e_rise, e_fall, e_busy;

  function automatic int eff(input int v, input bit quad);
    int h;
    h = (v == 0) ? 1 : v;
    if (quad && h < 2) h = 2;
    return h;
  endfunction

  task automatic model_reset();
    m_run = 0; m_ph = 0; m_h = 1; m_q = 0;
    e_pos = 0; e_neg = 0; e_rise = 0; e_fall = 0; e_busy = 0;
  endtask

  task automatic model_edge();
    bit prim, sec, use_src;
    int since;
    e_rise = 0; e_fall = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_run && !en) begin
      // Idle: levels follow the live configuration.
      prim = 0; sec = (mode == 2'd1); use_src = src;
      e_pos = use_src ? prim : sec; e_neg = use_src ? sec : prim; e_busy = 0;
    end else begin
      bit stopped = 0;
      if (!m_run) begin
        m_run = 1; m_mode = mode; m_src = src;
        m_h = eff(int'(hp), mode == 2'd2); m_q = m_h / 2; m_ph = 0; e_rise = 1;
      end else begin
        m_ph++;
        if (m_ph == 2 * m_h) begin
          if (en) begin
            m_h = eff(int'(hp), m_mode == 2'd2); m_q = m_h / 2; m_ph = 0; e_rise = 1;
          end else begin
            m_run = 0; stopped = 1;
          end
        end else if (m_ph == m_h) begin
          e_fall = 1;
        end
      end
      if (stopped) begin
        // Final low half done; secondary already settled (1 only in differential).
        prim = 0; sec = (m_mode == 2'd1);
        e_busy = 0;
      end else begin
        prim = (m_ph < m_h);
        since = prim ? m_ph : m_ph - m_h;
        if (m_mode == 2'd1)      sec = ~prim;
        else if (m_mode == 2'd2) sec = (since >= m_q) ? prim : ~prim;
        else                     sec = 0;
        e_busy = 1;
      end
      e_pos = m_src ? prim : sec; e_neg = m_src ? sec : prim;
    end
  endtask

  task automatic compare(input string pfx);
    check({pfx, "_pos"},  pins.pos, e_pos);
    check({pfx, "_neg"},  pins.neg, e_neg);
    check({pfx, "_rise"}, rise, e_rise);
    check({pfx, "_fall"}, fall, e_fall);
    check({pfx, "_busy"}, busy, e_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare("cyc");
  endtask

  task automatic seg(input bit s, input bit [1:0] m, input int h, input int on_c, input int off_c);
    src = s; mode = m; hp = CW'(h); en = 1;
    repeat (on_c) tick();
    en = 0;
    repeat (off_c) tick();
  endtask

  initial begin
    en = 0; src = 1; mode = 2'd1; hp = 4;
    model_reset();
    #2;
    compare("rst");
    repeat (2) tick();
    rst_n = 1;
    repeat (3) tick();

    // Single-ended, pos primary, H=4.
    seg(1, 2'd0, 4, 40, 12);
    // Differential, neg primary, H=0 clamps to 1.
    seg(0, 2'd1, 0, 20, 4);
    // Quad-state H=6 (Q=3), then H=1 acting as H=2/Q=1.
    seg(1, 2'd2, 6, 40, 15);
    seg(0, 2'd2, 1, 20, 6);

    // Graceful stop mid high-half with H=5, then re-enable while stopping.
    src = 1; mode = 2'd0; hp = 5; en = 1;
    repeat (12) tick();
    en = 0;
    repeat (4) tick();
    en = 1;
    repeat (10) tick();
    en = 0;
    repeat (14) tick();

    // Half-period change mid-high and config toggles mid-run.
    src = 1; mode = 2'd1; hp = 4; en = 1;
    repeat (2) tick();
    hp = 2; mode = 2'd2; src = 0;
    repeat (20) tick();
    en = 0;
    repeat (10) tick();

    // Asynchronous reset between edges during a quad-state run.
    src = 1; mode = 2'd2; hp = 4; en = 1;
    repeat (7) tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    compare("arst");
    repeat (2) tick();
    #2 rst_n = 1;
    repeat (25) tick();
    en = 0;
    repeat (10) tick();

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom % 10 == 0) en = ~en;
      if ($urandom % 16 == 0) hp = CW'($urandom % 9);
      if ($urandom % 24 == 0) mode = 2'($urandom % 4);
      if ($urandom % 24 == 0) src = 1'($urandom % 2);
      tick();
    end
    en = 0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
